// File: rtl/sha512_padder.sv
// sha512_padder
//   Streams a message into a SHA-512 core and appends the standard padding:
//   a 0x80 marker byte, zero words, and a 128-bit big-endian bit length.
//   The total output is always a multiple of 16 words (1024-bit blocks).
//   Message words pass through with zero added latency. The padder then
//   emits its own words, each held stable until the core acknowledges it.
//
// Configuration macro: SHA512_PADDER_BYTE_EN
//   defined   : data_bytes (0..8) selects how many bytes of the last word are
//               valid. 0 encodes the empty message.
//   undefined : every message is a whole number of 64-bit words, and
//               data_bytes is ignored.
//
// Parameters
//   LEN_W          width of the bit-length counter. The upper 128-LEN_W bits
//                  of the length field are zero, and the counter wraps
//                  silently.
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-low
//   data_in        message word, big-endian, first byte in [63:56]
//   data_valid     data_in is valid
//   data_last      data_in is the final message word
//   data_bytes     valid bytes in the last word, MSB-aligned
//   data_ready     word accepted when data_valid && data_ready
//   new_msg        one-cycle pulse with the first word of a message
//   msg_word       padded word to the core
//   msg_word_valid msg_word is valid
//   msg_word_ack   core consumed msg_word this cycle
//   msg_complete   one-cycle pulse after the low length word is acked
module sha512_padder #(
    parameter int LEN_W = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] data_in,
    input  logic        data_valid,
    input  logic        data_last,
    input  logic [3:0]  data_bytes,
    output logic        data_ready,
    output logic        new_msg,
    output logic [63:0] msg_word,
    output logic        msg_word_valid,
    input  logic        msg_word_ack,
    output logic        msg_complete
);

    typedef enum logic [2:0] {IDLE, DATA, PAD, LEN_HI, LEN_LO, DONE} state_t;

    localparam logic [63:0] MARKER = 64'h8000_0000_0000_0000;

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             marker_q, marker_d;   // 0x80 word still owed by PAD
    logic             new_msg_q, new_msg_d;

    logic [3:0]       idx_inc;
    logic [127:0]     len_field;
    logic [63:0]      last_word;
    logic             last_has_marker;
    logic [LEN_W-1:0] last_bits;

    logic             data_ready_c, valid_c, complete_c;
    logic [63:0]      word_c;

    assign idx_inc   = idx_q + 4'd1;
    assign len_field = 128'(len_q);

`ifdef SHA512_PADDER_BYTE_EN
    // Keep the top nb bytes, put 0x80 in byte nb, and zero everything below.
    function automatic logic [63:0] pad_last(input logic [63:0] w, input logic [3:0] nb);
        logic [5:0]  sh;
        logic [63:0] keep;
        if (nb >= 4'd8) return w;
        sh   = {nb[2:0], 3'b000};
        keep = ~(64'hFFFF_FFFF_FFFF_FFFF >> sh);
        return (w & keep) | (MARKER >> sh);
    endfunction

    logic [3:0] nb_eff;

    always_comb begin
        nb_eff          = (data_bytes > 4'd8) ? 4'd8 : data_bytes;
        last_word       = pad_last(data_in, nb_eff);
        last_has_marker = (nb_eff != 4'd8);
        last_bits       = LEN_W'({nb_eff, 3'b000});
    end
`else
    logic unused_data_bytes;

    assign unused_data_bytes = ^data_bytes;
    assign last_word         = data_in;
    assign last_has_marker   = 1'b0;
    assign last_bits         = LEN_W'(64);
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        len_d        = len_q;
        marker_d     = marker_q;
        new_msg_d    = 1'b0;
        data_ready_c = 1'b0;
        valid_c      = 1'b0;
        complete_c   = 1'b0;
        word_c       = '0;
        case (state_q)
            IDLE: begin
                if (data_valid) begin
                    state_d   = DATA;
                    idx_d     = '0;
                    len_d     = '0;
                    marker_d  = 1'b0;
                    new_msg_d = 1'b1;
                end
            end
            DATA: begin
                valid_c      = data_valid;
                data_ready_c = msg_word_ack;
                word_c       = data_last ? last_word : data_in;
                if (data_valid && msg_word_ack) begin
                    idx_d = idx_inc;
                    if (data_last) begin
                        len_d    = len_q + last_bits;
                        marker_d = !last_has_marker;
                        // If the marker already went out in this word and the
                        // next slot is 14, there is no room for any zero words.
                        state_d  = (last_has_marker && idx_inc == 4'd14) ? LEN_HI : PAD;
                    end else begin
                        len_d = len_q + LEN_W'(64);
                    end
                end
            end
            PAD: begin
                valid_c = 1'b1;
                word_c  = marker_q ? MARKER : 64'd0;
                if (msg_word_ack) begin
                    idx_d    = idx_inc;
                    marker_d = 1'b0;
                    // A marker at slot 14 or 15 leaves idx_inc != 14. PAD then
                    // wraps through a full extra block of zero words.
                    if (idx_inc == 4'd14) state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                valid_c = 1'b1;
                word_c  = len_field[127:64];
                if (msg_word_ack) begin
                    idx_d   = idx_inc;
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                valid_c = 1'b1;
                word_c  = len_field[63:0];
                if (msg_word_ack) begin
                    idx_d   = idx_inc;
                    state_d = DONE;
                end
            end
            DONE: begin
                complete_c = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            marker_q  <= 1'b0;
            new_msg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            marker_q  <= marker_d;
            new_msg_q <= new_msg_d;
        end
    end

    // Outputs are forced quiet while reset is low. This also covers the cycle
    // before the reset edge, when the state may still be mid-message.
    assign data_ready     = reset & data_ready_c;
    assign msg_word_valid = reset & valid_c;
    assign msg_complete   = reset & complete_c;
    assign new_msg        = reset & new_msg_q;
    assign msg_word       = reset ? word_c : 64'd0;

endmodule

// File: tb/tb_sha512_padder.sv
module tb_sha512_padder;

    localparam logic [63:0] MARKER = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] data_in;
    logic        data_valid;
    logic        data_last;
    logic [3:0]  data_bytes;
    logic        data_ready;
    logic        new_msg;
    logic [63:0] msg_word;
    logic        msg_word_valid;
    logic        msg_word_ack;
    logic        msg_complete;

    int checks   = 0;
    int failures = 0;

    logic [63:0] src   [16];
    logic [63:0] exp_w [64];
    logic [63:0] got   [64];
    int          exp_n;
    int          got_n;

    always #5 clk = ~clk;

    sha512_padder #(.LEN_W(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .data_last     (data_last),
        .data_bytes    (data_bytes),
        .data_ready    (data_ready),
        .new_msg       (new_msg),
        .msg_word      (msg_word),
        .msg_word_valid(msg_word_valid),
        .msg_word_ack  (msg_word_ack),
        .msg_complete  (msg_complete)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Expected output for an n-word whole-word message.
    task automatic build_exp(input int n);
        for (int k = 0; k < 64; k++) exp_w[k] = 64'd0;
        for (int k = 0; k < n; k++) exp_w[k] = src[k];
        exp_w[n] = MARKER;
        exp_n = (n <= 13) ? 16 : 32;
        exp_w[exp_n-1] = 64'(n * 64);
    endtask

    // Sends src[0..n-1] and acts as the core. The core holds ack low for 5
    // cycles when the output count reaches sa and again when it reaches sb.
    task automatic run_msg(input int n, input logic [3:0] lb, input int sa, input int sb,
                           input string tag);
        int  i      = 0;
        int  cyc    = 0;
        int  left_a = 5;
        int  left_b = 5;
        int  nm_cnt = 0;
        int  nm_at  = -1;
        bit  done   = 1'b0;
        bit  stall;
        got_n = 0;
        for (int k = 0; k < 64; k++) got[k] = 64'hDEAD_BEEF_DEAD_BEEF;
        while (!done && cyc < 300) begin
            @(negedge clk);
            data_valid   = (i < n);
            data_in      = (i < n) ? src[i] : 64'd0;
            data_last    = (i == n - 1);
            data_bytes   = lb;
            msg_word_ack = 1'b1;
            stall        = 1'b0;
            if (got_n == sa && left_a > 0) begin
                msg_word_ack = 1'b0; left_a--; stall = 1'b1;
            end else if (got_n == sb && left_b > 0) begin
                msg_word_ack = 1'b0; left_b--; stall = 1'b1;
            end
            #1;
            if (stall) begin
                chk($sformatf("%s_stall_valid_%0d", tag, got_n), 64'(msg_word_valid), 64'd1);
                chk($sformatf("%s_stall_ready_%0d", tag, got_n), 64'(data_ready), 64'd0);
                chk($sformatf("%s_stall_word_%0d", tag, got_n), msg_word, exp_w[got_n]);
            end
            if (new_msg) begin
                nm_cnt++;
                nm_at = got_n;
            end
            if (msg_complete) begin
                done = 1'b1;
                chk($sformatf("%s_done_ready", tag), 64'(data_ready), 64'd0);
            end
            if (msg_word_valid && msg_word_ack && got_n < 64) begin
                got[got_n] = msg_word;
                got_n++;
            end
            if (data_valid && data_ready) i++;
            cyc++;
        end
        data_valid   = 1'b0;
        data_last    = 1'b0;
        msg_word_ack = 1'b0;
        chk($sformatf("%s_completed", tag), 64'(done), 64'd1);
        chk($sformatf("%s_count", tag), 64'(got_n), 64'(exp_n));
        chk($sformatf("%s_new_msg_cnt", tag), 64'(nm_cnt), 64'd1);
        chk($sformatf("%s_new_msg_at", tag), 64'(nm_at), 64'd0);
        for (int k = 0; k < exp_n; k++)
            chk($sformatf("%s_w%0d", tag, k), got[k], exp_w[k]);
        @(negedge clk);
        #1;
        chk($sformatf("%s_complete_pulse", tag), 64'(msg_complete), 64'd0);
    endtask

    initial begin
        int acc;
        int mcs;
        int cyc;

        // Reset with active-looking inputs: every output must stay quiet.
        reset        = 1'b0;
        data_valid   = 1'b1;
        data_in      = 64'hFFFF_FFFF_FFFF_FFFF;
        data_last    = 1'b1;
        data_bytes   = 4'd8;
        msg_word_ack = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 64'(data_ready), 64'd0);
        chk("rst_valid", 64'(msg_word_valid), 64'd0);
        chk("rst_new_msg", 64'(new_msg), 64'd0);
        chk("rst_complete", 64'(msg_complete), 64'd0);
        chk("rst_word", msg_word, 64'd0);
        @(negedge clk);
        reset        = 1'b1;
        data_valid   = 1'b0;
        msg_word_ack = 1'b0;
        @(negedge clk);

        // One whole word: word, marker, 12 zeros, 0, 0x40.
        src[0] = 64'h0123_4567_89AB_CDEF;
        build_exp(1);
        run_msg(1, 4'd8, -1, -1, "one");
        chk("one_len_lo", got[15], 64'h40);

        // 896 bits: the marker lands at index 14, so a full extra block is added.
        for (int k = 0; k < 14; k++) src[k] = 64'hA5A5_0000_0000_0000 | 64'(k);
        build_exp(14);
        run_msg(14, 4'd8, -1, -1, "w14");
        chk("w14_marker", got[14], MARKER);
        chk("w14_zero15", got[15], 64'd0);
        chk("w14_len_lo", got[31], 64'h380);

        // 13 words: the marker lands at index 13, with no zero words before the length.
        for (int k = 0; k < 13; k++) src[k] = 64'h1111_2222_0000_0000 | 64'(k);
        build_exp(13);
        run_msg(13, 4'd8, -1, -1, "w13");
        chk("w13_marker", got[13], MARKER);
        chk("w13_len_lo", got[15], 64'h340);

        // 15 words: the marker lands at index 15, which wraps.
        for (int k = 0; k < 15; k++) src[k] = 64'h0F0F_0000_0000_0000 | 64'(k);
        build_exp(15);
        run_msg(15, 4'd8, -1, -1, "w15");
        chk("w15_marker", got[15], MARKER);
        chk("w15_len_lo", got[31], 64'h3C0);

        // Ack held low for 5 cycles in DATA (word 1) and in PAD (marker word 3).
        src[0] = 64'hCAFE_0000_0000_0001;
        src[1] = 64'hCAFE_0000_0000_0002;
        src[2] = 64'hCAFE_0000_0000_0003;
        build_exp(3);
        run_msg(3, 4'd8, 1, 3, "stall");
        chk("stall_len_lo", got[15], 64'hC0);

        // Abort a message after 8 accepted words, then run a clean message.
        for (int k = 0; k < 16; k++) src[k] = 64'h7777_0000_0000_0000 | 64'(k);
        acc = 0;
        mcs = 0;
        cyc = 0;
        while (acc < 8 && cyc < 100) begin
            @(negedge clk);
            data_valid   = 1'b1;
            data_in      = src[acc];
            data_last    = 1'b0;
            data_bytes   = 4'd8;
            msg_word_ack = 1'b1;
            #1;
            if (msg_complete) mcs++;
            if (data_valid && data_ready) acc++;
            cyc++;
        end
        chk("abort_accepted", 64'(acc), 64'd8);
        @(negedge clk);
        reset = 1'b0;
        #1;
        if (msg_complete) mcs++;
        chk("abort_rst_ready", 64'(data_ready), 64'd0);
        chk("abort_rst_valid", 64'(msg_word_valid), 64'd0);
        chk("abort_rst_word", msg_word, 64'd0);
        @(negedge clk);
        #1;
        if (msg_complete) mcs++;
        @(negedge clk);
        reset        = 1'b1;
        data_valid   = 1'b0;
        msg_word_ack = 1'b0;
        #1;
        if (msg_complete) mcs++;
        chk("abort_valid_after", 64'(msg_word_valid), 64'd0);
        chk("abort_no_complete", 64'(mcs), 64'd0);
        src[0] = 64'h0123_4567_89AB_CDEF;
        build_exp(1);
        run_msg(1, 4'd8, -1, -1, "post_abort");

`ifdef SHA512_PADDER_BYTE_EN
        // "abc": the low bytes of data_in carry garbage that must be masked.
        src[0] = 64'h6162_63FF_FFFF_FFFF;
        for (int k = 0; k < 64; k++) exp_w[k] = 64'd0;
        exp_w[0]  = 64'h6162_6380_0000_0000;
        exp_w[15] = 64'h18;
        exp_n     = 16;
        run_msg(1, 4'd3, -1, -1, "abc");

        // The empty message is encoded as one last word with zero valid bytes.
        src[0] = 64'h1234_5678_9ABC_DEF0;
        for (int k = 0; k < 64; k++) exp_w[k] = 64'd0;
        exp_w[0] = MARKER;
        exp_n    = 16;
        run_msg(1, 4'd0, -1, -1, "empty");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
